uart_tx_fifo_param: RTL and testbench



---
 rtl/uart_tx_fifo_param.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a small input FIFO and valid/ready producer handshake.
// Frames go back-to-back without idle gaps while words remain queued.
module uart_tx_fifo_param #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS);

  if (CLK_DIV < 2) begin : g_err_div
    $error("CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_err_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   parity_q;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  logic                   bit_end_c;
  logic                   frame_end_c;
  logic                   push_c;
  logic                   pop_c;
  logic [CW-1:0]          count_nxt_c;
  logic [DATA_BITS-1:0]   head_c;
  logic                   head_par_c;
  logic                   line_c;

  assign bit_end_c   = (div_cnt == DW'(CLK_DIV - 1));
  assign frame_end_c = (state == S_STOP) && bit_end_c && (bit_cnt == BW'(STOP_BITS - 1));
  assign push_c      = in_valid && in_ready;
  assign pop_c       = (fifo_count != '0) && ((state == S_IDLE) || frame_end_c);
  assign count_nxt_c = fifo_count + CW'(push_c) - CW'(pop_c);
  assign head_c      = mem[rd_ptr];
  assign head_par_c  = (PARITY == 2) ? ~(^head_c) : (^head_c);

  // Line level for the current state; registered into uart_tx one cycle later.
  always_comb begin
    line_c = 1'b1;
    case (state)
      S_START:  line_c = 1'b0;
      S_DATA:   line_c = shift_q[0];
      S_PARITY: line_c = parity_q;
      default:  line_c = 1'b1;
    endcase
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      uart_tx    <= line_c;
      fifo_count <= count_nxt_c;
      in_ready   <= (count_nxt_c < CW'(FIFO_DEPTH));
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);

      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (pop_c) begin
            shift_q  <= head_c;
            parity_q <= head_par_c;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            div_cnt <= '0;
            shift_q <= shift_q >> 1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end_c) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_STOP;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_STOP: begin
          if (bit_end_c) begin
            div_cnt <= '0;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              // Chain straight into the next frame when a word is waiting.
              if (pop_c) begin
                shift_q  <= head_c;
                parity_q <= head_par_c;
                state    <= S_START;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: default, even/odd parity with two
// stop bits, and a narrow 5-bit/CLK_DIV=3 instance share one clock.
module tb_uart_tx_fifo_param;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [3:0] in_valid_v;
  logic [3:0] in_ready_v;
  logic [3:0] uart_tx_v;
  logic [3:0] busy_v;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;
  int         checks;
  int         errors;
  logic       cap_ln [0:1023];
  logic       cap_bz [0:1023];

  uart_tx_fifo_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_def (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .uart_tx(uart_tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt0));
  uart_tx_fifo_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .uart_tx(uart_tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt1));
  uart_tx_fifo_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .uart_tx(uart_tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt2));
  uart_tx_fifo_param #(.CLK_DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_narrow (
    .clk(clk), .rst(rst), .in_data(in_data[4:0]), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .uart_tx(uart_tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one word into an idle instance, then record line and busy for ncyc cycles.
  // Sample c is taken at the falling edge after rising edge c (edge 1 accepts the word).
  task automatic capture(input int idx, input logic [7:0] word, input int ncyc);
    @(negedge clk);
    in_data         = word;
    in_valid_v[idx] = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      in_valid_v[idx] = 1'b0;
      cap_ln[c] = uart_tx_v[idx];
      cap_bz[c] = busy_v[idx];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({uart_tx_v, busy_v, in_ready_v, cnt0} !== {4'hF, 4'h0, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_hold got tx=%b busy=%b rdy=%b cnt=%0d want tx=1111 busy=0000 rdy=0000 cnt=0",
               uart_tx_v, busy_v, in_ready_v, cnt0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({uart_tx_v, busy_v, in_ready_v, cnt0} !== {4'hF, 4'h0, 4'hF, 3'd0}) begin
      errors++;
      $display("FAIL reset_release got tx=%b busy=%b rdy=%b cnt=%0d want tx=1111 busy=0000 rdy=1111 cnt=0",
               uart_tx_v, busy_v, in_ready_v, cnt0);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] golden;
    int fall, first_busy, bcnt, errs;
    logic exp;
    golden = {1'b1, 8'h2B, 1'b0};
    capture(0, 8'h2B, 180);
    fall = 0; first_busy = 0; bcnt = 0; errs = 0;
    for (int c = 1; c <= 180; c++) begin
      if (fall == 0 && cap_ln[c] === 1'b0) fall = c;
      if (first_busy == 0 && cap_bz[c] === 1'b1) first_busy = c;
      if (cap_bz[c] === 1'b1) bcnt++;
      exp = (c >= 3 && c < 163) ? golden[(c - 3) / 16] : 1'b1;
      if (cap_ln[c] !== exp) errs++;
    end
    checks++;
    if (fall !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", fall); end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (cap_ln[3 + 16 * b + 8] !== golden[b]) begin
        errors++;
        $display("FAIL single_bit%0d got %b want %b", b, cap_ln[3 + 16 * b + 8], golden[b]);
      end
    end
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL single_line_cycles got %0d bad want 0", errs); end
    checks++;
    if (bcnt !== 160 || first_busy !== 2) begin
      errors++;
      $display("FAIL single_busy got len=%0d start=%0d want len=160 start=2", bcnt, first_busy);
    end
  endtask

  task automatic test_parity();
    logic [11:0] golden;
    logic par, exp;
    int bcnt, errs;
    for (int i = 1; i <= 2; i++) begin
      par = (i == 2);
      golden = {2'b11, par, 8'h2B, 1'b0};
      capture(i, 8'h2B, 210);
      bcnt = 0; errs = 0;
      for (int c = 1; c <= 210; c++) begin
        if (cap_bz[c] === 1'b1) bcnt++;
        exp = (c >= 3 && c < 195) ? golden[(c - 3) / 16] : 1'b1;
        if (cap_ln[c] !== exp) errs++;
      end
      checks++;
      if (cap_ln[3 + 16 * 9 + 8] !== par) begin
        errors++;
        $display("FAIL parity%0d_bit got %b want %b", i, cap_ln[3 + 16 * 9 + 8], par);
      end
      checks++;
      if (errs !== 0) begin errors++; $display("FAIL parity%0d_line_cycles got %0d bad want 0", i, errs); end
      checks++;
      if (bcnt !== 192) begin errors++; $display("FAIL parity%0d_busy_len got %0d want 192", i, bcnt); end
    end
  endtask

  task automatic test_narrow();
    logic [6:0] golden;
    logic exp;
    int bcnt, errs;
    golden = {1'b1, 5'h13, 1'b0};
    capture(3, 8'h13, 40);
    bcnt = 0; errs = 0;
    for (int c = 1; c <= 40; c++) begin
      if (cap_bz[c] === 1'b1) bcnt++;
      exp = (c >= 3 && c < 24) ? golden[(c - 3) / 3] : 1'b1;
      if (cap_ln[c] !== exp) errs++;
    end
    checks++;
    if (errs !== 0) begin errors++; $display("FAIL narrow_line_cycles got %0d bad want 0", errs); end
    checks++;
    if (bcnt !== 21) begin errors++; $display("FAIL narrow_busy_len got %0d want 21", bcnt); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [6] = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h11, 8'hF0};
    int acc_at [6];
    int k, rise, gaps;
    logic acc;
    logic [7:0] got;
    k = 0; rise = 0; gaps = 0;
    @(negedge clk);
    in_data = w[0];
    in_valid_v[0] = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      acc = in_valid_v[0] & in_ready_v[0];
      @(negedge clk);
      if (acc) begin
        acc_at[k] = c;
        k++;
        if (k == 6) in_valid_v[0] = 1'b0; else in_data = w[k];
      end
      cap_ln[c] = uart_tx_v[0];
      if (c >= 2 && c <= 961 && busy_v[0] !== 1'b1) gaps++;
      if (c > 20 && rise == 0 && in_ready_v[0] === 1'b1) rise = c;
      if (c == 20) begin
        checks++;
        if ({k[3:0], cnt0, in_ready_v[0]} !== {4'd5, 3'd4, 1'b0}) begin
          errors++;
          $display("FAIL fifo_fill got acc=%0d cnt=%0d rdy=%b want acc=5 cnt=4 rdy=0", k, cnt0, in_ready_v[0]);
        end
      end
      if (c == 970) begin
        checks++;
        if ({busy_v[0], uart_tx_v[0], cnt0} !== {1'b0, 1'b1, 3'd0}) begin
          errors++;
          $display("FAIL fifo_drain got busy=%b tx=%b cnt=%0d want busy=0 tx=1 cnt=0", busy_v[0], uart_tx_v[0], cnt0);
        end
      end
    end
    checks++;
    if (rise !== 162) begin errors++; $display("FAIL fifo_ready_rise got %0d want 162", rise); end
    checks++;
    if (k !== 6 || acc_at[5] !== 163) begin
      errors++;
      $display("FAIL fifo_sixth_accept got n=%0d at=%0d want n=6 at=163", k, acc_at[5]);
    end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL fifo_busy_gaps got %0d want 0", gaps); end
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 8; b++) got[b] = cap_ln[3 + 160 * f + 16 * (b + 1) + 8];
      checks++;
      if (got !== w[f]) begin errors++; $display("FAIL fifo_order%0d got %h want %h", f, got, w[f]); end
    end
  endtask

  task automatic test_back_to_back();
    int idx, gaps;
    logic acc;
    logic [9:0] fr, exp;
    int rel, f, pos;
    idx = 0; gaps = 0; fr = '0;
    @(negedge clk);
    in_data = 8'h00;
    in_valid_v[0] = 1'b1;
    for (int c = 1; c <= 3 + 256 * 160 + 5; c++) begin
      acc = in_valid_v[0] & in_ready_v[0];
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx == 256) in_valid_v[0] = 1'b0; else in_data = 8'(idx);
      end
      if (c >= 2 && c <= 1 + 256 * 160 && busy_v[0] !== 1'b1) gaps++;
      rel = c - 3;
      if (rel >= 0 && rel < 256 * 160) begin
        f = rel / 160;
        pos = rel % 160;
        if (pos % 16 == 8) fr[pos / 16] = uart_tx_v[0];
        if (pos == 159) begin
          exp = {1'b1, 8'(f), 1'b0};
          checks++;
          if (fr !== exp) begin errors++; $display("FAIL stream_frame%0d got %b want %b", f, fr, exp); end
        end
      end
    end
    checks++;
    if (idx !== 256 || gaps !== 0) begin
      errors++;
      $display("FAIL stream_flow got accepted=%0d gaps=%0d want accepted=256 gaps=0", idx, gaps);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w [4] = '{8'h00, 8'h55, 8'h66, 8'h77};
    int k, quiet, errs, bcnt;
    logic acc, exp;
    logic [9:0] golden;
    k = 0;
    @(negedge clk);
    in_data = w[0];
    in_valid_v[0] = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      acc = in_valid_v[0] & in_ready_v[0];
      @(negedge clk);
      if (acc) begin
        k++;
        if (k == 4) in_valid_v[0] = 1'b0; else in_data = w[k];
      end
    end
    checks++;
    if ({cnt0, busy_v[0], uart_tx_v[0]} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_pre got cnt=%0d busy=%b tx=%b want cnt=3 busy=1 tx=0", cnt0, busy_v[0], uart_tx_v[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({uart_tx_v[0], busy_v[0], cnt0, in_ready_v[0]} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_abort got tx=%b busy=%b cnt=%0d rdy=%b want tx=1 busy=0 cnt=0 rdy=0",
               uart_tx_v[0], busy_v[0], cnt0, in_ready_v[0]);
    end
    rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uart_tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cnt0 !== 3'd0) quiet++;
    end
    checks++;
    if (quiet !== 0) begin errors++; $display("FAIL midreset_no_resume got %0d active want 0", quiet); end
    golden = {1'b1, 8'hC3, 1'b0};
    capture(0, 8'hC3, 180);
    errs = 0; bcnt = 0;
    for (int c = 1; c <= 180; c++) begin
      if (cap_bz[c] === 1'b1) bcnt++;
      exp = (c >= 3 && c < 163) ? golden[(c - 3) / 16] : 1'b1;
      if (cap_ln[c] !== exp) errs++;
    end
    checks++;
    if (errs !== 0 || bcnt !== 160) begin
      errors++;
      $display("FAIL midreset_clean_frame got bad=%0d busy=%0d want bad=0 busy=160", errs, bcnt);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_data    = '0;
    in_valid_v = '0;
    test_reset();
    test_single_frame();
    test_parity();
    test_narrow();
    repeat (5) @(negedge clk);
    test_fifo_full();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
